boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Controls the bootloader write path. Consumes the word stream produced by the byte-to-word assembler and writes the program image into instruction memory at incrementing word addresses.
- Holds the CPU in reset while loading. Validates the image against a length header and an XOR checksum, then releases the CPU, or flags an error.
- Sits between the word assembler output and the instruction-memory write port. Drives the CPU reset line.

Parameters:
- WORD_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest legal payload length in words; must be <= 2**ADDR_WIDTH.
- BASE_ADDR, 0, word address of the first payload word.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted words once a load has started.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- word_in  input  WORD_WIDTH  word from the assembler.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  sequencer accepts word_in this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  instruction-memory word address.
- imem_wdata  output  WORD_WIDTH  instruction-memory write data.
- cpu_rst_n  output  1  CPU reset, active-low; 0 holds the CPU.
- boot_done  output  1  image loaded and verified.
- boot_error  output  1  load failed.
- error_code  output  2  0 = none, 1 = bad length, 2 = checksum mismatch, 3 = timeout.
- words_loaded  output  ADDR_WIDTH+1  payload words written so far.
- boot_req  input  1  restart request, honoured only in DONE or ERROR.

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0, including cpu_rst_n (CPU held in reset). State resets to WAIT_LEN.
- Handshake: a word transfers on any rising clk edge where word_valid && word_ready. word_ready is 1 exactly in WAIT_LEN, LOAD and WAIT_CSUM; it is a function of state only and never depends on word_valid.
- Stream format:
  - word 0 = payload length N (unsigned);
  - then N payload words;
  - then one checksum word = XOR of all N payload words.
- WAIT_LEN:
  - Waits without limit; the timeout counter is not running.
  - On transfer, latch N. N > MAX_WORDS: go to ERROR, error_code=1.
  - N == 0: go to WAIT_CSUM with accumulator 0.
  - Otherwise: go to LOAD, index=0, accumulator=0.
- LOAD:
  - Each transfer registers imem_addr = BASE_ADDR + index (mod 2**ADDR_WIDTH), imem_wdata = word_in, imem_we = 1 for exactly one cycle (1-cycle latency after the transfer edge).
  - Each transfer also updates accumulator ^= word_in and increments index and words_loaded.
  - Back-to-back transfers produce a continuous imem_we pulse train, one write per word, with no bubbles.
  - After the Nth transfer, go to WAIT_CSUM.
- WAIT_CSUM: on transfer, compare word_in with the accumulator.
  - Equal: go to DONE.
  - Not equal: go to ERROR, error_code=2.
- Timeout (LOAD and WAIT_CSUM only):
  - The idle counter resets to 0 on every transfer and on state entry.
  - When it reaches TIMEOUT_CYCLES: go to ERROR, error_code=3.
  - If a transfer and the timeout land on the same cycle, the transfer wins.
- DONE: word_ready=0, boot_done=1, cpu_rst_n=1 from the first DONE cycle on.
- ERROR: word_ready=0, boot_error=1, cpu_rst_n stays 0, error_code holds its value.
- imem_we is 0 in every state except the cycle after a LOAD transfer; the length and checksum words are never written to memory.
- boot_req in DONE or ERROR: the next state is WAIT_LEN. Same cycle it clears boot_done, boot_error, error_code and words_loaded, and drives cpu_rst_n to 0. boot_req in any other state is ignored.
- Words presented in DONE or ERROR are not consumed (word_ready=0); upstream back-pressures.
- Reset mid-load aborts immediately. Memory contents already written are left as is; outputs return to reset values.

Test Plan:
- Nominal: stream 3, 0x00000013, 0x00100093, 0x00208113, checksum 0x00308193 with word_valid held high -> imem_we high 3 consecutive cycles at addr 0,1,2 with those data; boot_done=1; cpu_rst_n=1; words_loaded=3; word_ready=0 after the checksum.
- Bad checksum: length 2, words 0xAAAA5555 and 0x0000FFFF, checksum 0 -> both writes occur; boot_error=1; error_code=2; cpu_rst_n=0.
- Length bound: length MAX_WORDS+1=1025 -> ERROR, error_code=1, no imem_we pulse; length 0 then checksum 0 -> DONE, no writes.
- Timeout: TIMEOUT_CYCLES=50, length 4, send 2 words, then idle -> ERROR exactly 50 cycles after the last transfer, error_code=3. Separately, a word arriving on cycle 50 is accepted and no error is raised.
- Back-pressure/gaps: randomized word_valid gaps (<50 cycles), length 8 -> 8 writes at addr 0..7 in order, DONE; no write on any cycle without a preceding transfer.
- Restart and reset: after ERROR, pulse boot_req -> WAIT_LEN, flags cleared, a nominal reload reaches DONE. Assert rst_n low mid-LOAD -> outputs at reset values immediately, state WAIT_LEN after release.

Source files
------------

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - bootloader write path: length header, payload to imem, XOR checksum, CPU release
// Consumes a length-prefixed word stream, writes it to instruction memory and releases the CPU on a good checksum.
module boot_sequencer #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic [1:0]            error_code,
  output logic [ADDR_WIDTH:0]   words_loaded,
  input  logic                  boot_req
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_WAIT_LEN  = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_CSUM = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_ERROR     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            err_q, err_d;
  logic                  xfer;
  logic                  timed_out;

  assign word_ready = (state_q == S_WAIT_LEN) || (state_q == S_LOAD) || (state_q == S_WAIT_CSUM);
  assign xfer       = word_valid && word_ready;
  // The counter reaches TIMEOUT_CYCLES on the edge that would take it past this value.
  assign timed_out  = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT_LEN: begin
        if (xfer) begin
          cnt_d   = '0;
          acc_d   = '0;
          timer_d = '0;
          len_d   = word_in[ADDR_WIDTH:0];
          if (word_in > WORD_WIDTH'(MAX_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 2'd1;
          end else if (word_in == '0) begin
            state_d = S_WAIT_CSUM;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = ADDR_WIDTH'(BASE_ADDR) + cnt_q[ADDR_WIDTH-1:0];
          wdata_d = word_in;
          acc_d   = acc_q ^ word_in;
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
          if (cnt_d == len_q) state_d = S_WAIT_CSUM;
        end else if (timed_out) begin
          state_d = S_ERROR;
          err_d   = 2'd3;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_CSUM: begin
        if (xfer) begin
          if (word_in == acc_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = 2'd2;
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
          err_d   = 2'd3;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (boot_req) begin
          state_d = S_WAIT_LEN;
          cnt_d   = '0;
          err_d   = 2'd0;
        end
      end
      default: state_d = S_WAIT_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_LEN;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = (state_q == S_DONE);
  assign boot_done    = (state_q == S_DONE);
  assign boot_error   = (state_q == S_ERROR);
  assign error_code   = err_q;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed self-checking bench for boot_sequencer
// Writes seen on imem are logged at the falling edge and compared against hand-computed images.
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        boot_error;
  logic [1:0]  error_code;
  logic [10:0] words_loaded;
  logic        boot_req;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int spurious = 0;
  logic [9:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  logic        last_xfer = 1'b0;

  boot_sequencer #(
    .WORD_WIDTH(32), .ADDR_WIDTH(10), .MAX_WORDS(1024), .BASE_ADDR(0), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .boot_done(boot_done), .boot_error(boot_error), .error_code(error_code),
    .words_loaded(words_loaded), .boot_req(boot_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    last_xfer <= word_valid && word_ready;
  end

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
        wr_cyc[wr_cnt]  = cyc;
      end
      wr_cnt = wr_cnt + 1;
      if (!last_xfer) spurious = spurious + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    word_in = w;
    word_valid = 1'b1;
    while (!word_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!word_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: word_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    word_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic restart();
    word_valid = 1'b0;
    boot_req = 1'b1;
    @(posedge clk); #1;
    boot_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; word_valid = 1'b0; word_in = '0; boot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", imem_we); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cpu: got %0b want 0", cpu_rst_n); end
    checks++; if (boot_done !== 1'b0 || boot_error !== 1'b0) begin errors++; $display("FAIL rst_flags: got %0b%0b want 00", boot_done, boot_error); end
    checks++; if (error_code !== 2'd0 || words_loaded !== 11'd0) begin errors++; $display("FAIL rst_code: got %0d/%0d want 0/0", error_code, words_loaded); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", word_ready); end
  endtask

  task automatic test_nominal();
    logic [31:0] img [0:2];
    int base;
    img[0] = 32'h00000013; img[1] = 32'h00100093; img[2] = 32'h00208113;
    base = wr_cnt;
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(img[i]);
    send_word(32'h00308193);
    word_valid = 1'b0;
    checks++; if (wr_cnt - base !== 3) begin errors++; $display("FAIL nom_wcount: got %0d want 3", wr_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[base+i] !== 10'(i) || wr_data[base+i] !== img[i]) begin
        errors++; $display("FAIL nom_write%0d: got %0h/%h want %0h/%h", i, wr_addr[base+i], wr_data[base+i], i, img[i]);
      end
    end
    checks++; if (wr_cyc[base+2] - wr_cyc[base] !== 2) begin errors++; $display("FAIL nom_b2b: got span %0d want 2", wr_cyc[base+2] - wr_cyc[base]); end
    checks++; if (boot_done !== 1'b1 || cpu_rst_n !== 1'b1) begin errors++; $display("FAIL nom_done: got %0b/%0b want 1/1", boot_done, cpu_rst_n); end
    checks++; if (words_loaded !== 11'd3) begin errors++; $display("FAIL nom_words: got %0d want 3", words_loaded); end
    checks++; if (word_ready !== 1'b0 || boot_error !== 1'b0) begin errors++; $display("FAIL nom_ready: got %0b/%0b want 0/0", word_ready, boot_error); end
  endtask

  task automatic test_bad_checksum();
    int base;
    base = wr_cnt;
    send_word(32'd2);
    send_word(32'hAAAA5555);
    send_word(32'h0000FFFF);
    send_word(32'h00000000);
    word_valid = 1'b0;
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL csum_wcount: got %0d want 2", wr_cnt - base); end
    checks++; if (wr_data[base] !== 32'hAAAA5555 || wr_data[base+1] !== 32'h0000FFFF) begin errors++; $display("FAIL csum_data: got %h %h", wr_data[base], wr_data[base+1]); end
    checks++; if (boot_error !== 1'b1 || error_code !== 2'd2) begin errors++; $display("FAIL csum_err: got %0b/%0d want 1/2", boot_error, error_code); end
    checks++; if (cpu_rst_n !== 1'b0 || word_ready !== 1'b0) begin errors++; $display("FAIL csum_cpu: got %0b/%0b want 0/0", cpu_rst_n, word_ready); end
  endtask

  task automatic test_restart();
    restart();
    checks++; if (boot_error !== 1'b0 || boot_done !== 1'b0) begin errors++; $display("FAIL rs_flags: got %0b/%0b want 0/0", boot_error, boot_done); end
    checks++; if (error_code !== 2'd0 || words_loaded !== 11'd0) begin errors++; $display("FAIL rs_clear: got %0d/%0d want 0/0", error_code, words_loaded); end
    checks++; if (cpu_rst_n !== 1'b0 || word_ready !== 1'b1) begin errors++; $display("FAIL rs_state: got %0b/%0b want 0/1", cpu_rst_n, word_ready); end
    test_nominal();
  endtask

  task automatic test_bad_length();
    int base;
    base = wr_cnt;
    send_word(32'd1025);
    idle(3);
    checks++; if (boot_error !== 1'b1 || error_code !== 2'd1) begin errors++; $display("FAIL len_err: got %0b/%0d want 1/1", boot_error, error_code); end
    checks++; if (wr_cnt !== base) begin errors++; $display("FAIL len_nowrite: got %0d writes want 0", wr_cnt - base); end
  endtask

  task automatic test_zero_len();
    int base;
    base = wr_cnt;
    send_word(32'd0);
    send_word(32'd0);
    idle(2);
    checks++; if (boot_done !== 1'b1 || cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b/%0b want 1/1", boot_done, cpu_rst_n); end
    checks++; if (wr_cnt !== base || words_loaded !== 11'd0) begin errors++; $display("FAIL zero_nowrite: got %0d/%0d want 0/0", wr_cnt - base, words_loaded); end
  endtask

  task automatic test_timeout();
    send_word(32'd4);
    send_word(32'd11);
    send_word(32'd22);
    idle(49);
    checks++; if (boot_error !== 1'b0) begin errors++; $display("FAIL to_early: got %0b want 0 at 49 idle cycles", boot_error); end
    idle(1);
    checks++; if (boot_error !== 1'b1 || error_code !== 2'd3) begin errors++; $display("FAIL to_err: got %0b/%0d want 1/3", boot_error, error_code); end
    checks++; if (words_loaded !== 11'd2 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL to_words: got %0d/%0b want 2/0", words_loaded, cpu_rst_n); end
  endtask

  task automatic test_timeout_edge();
    send_word(32'd1);
    idle(49);
    send_word(32'h0000005A);
    word_valid = 1'b0;
    checks++; if (boot_error !== 1'b0 || words_loaded !== 11'd1) begin errors++; $display("FAIL toe_accept: got %0b/%0d want 0/1", boot_error, words_loaded); end
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h0000005A) begin errors++; $display("FAIL toe_write: got %0b/%h want 1/0000005a", imem_we, imem_wdata); end
    send_word(32'h0000005A);
    word_valid = 1'b0;
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL toe_done: got %0b want 1", boot_done); end
  endtask

  task automatic test_gaps();
    int gap [0:7];
    logic [31:0] d [0:7];
    logic [31:0] csum;
    int base;
    gap = '{0, 3, 7, 1, 12, 0, 5, 20};
    csum = '0;
    for (int i = 0; i < 8; i++) begin
      d[i] = 32'hC0DE0000 | (32'(i) * 32'h00010103);
      csum = csum ^ d[i];
    end
    base = wr_cnt;
    send_word(32'd8);
    for (int i = 0; i < 8; i++) begin
      idle(gap[i]);
      send_word(d[i]);
    end
    idle(4);
    send_word(csum);
    word_valid = 1'b0;
    checks++; if (wr_cnt - base !== 8) begin errors++; $display("FAIL gap_wcount: got %0d want 8", wr_cnt - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[base+i] !== 10'(i) || wr_data[base+i] !== d[i]) begin
        errors++; $display("FAIL gap_write%0d: got %0h/%h want %0h/%h", i, wr_addr[base+i], wr_data[base+i], i, d[i]);
      end
    end
    checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL gap_done: got %0b want 1", boot_done); end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL gap_spurious: got %0d writes without transfer want 0", spurious); end
  endtask

  task automatic test_reset_midload();
    send_word(32'd4);
    send_word(32'h11111111);
    send_word(32'h22222222);
    word_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin errors++; $display("FAIL mid_imem: got %0b/%0h/%h want 0/0/0", imem_we, imem_addr, imem_wdata); end
    checks++; if (words_loaded !== 11'd0 || error_code !== 2'd0) begin errors++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", words_loaded, error_code); end
    checks++; if (cpu_rst_n !== 1'b0 || boot_done !== 1'b0 || boot_error !== 1'b0) begin errors++; $display("FAIL mid_flags: got %0b%0b%0b want 000", cpu_rst_n, boot_done, boot_error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b want 1", word_ready); end
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    restart();
    test_bad_checksum();
    test_restart();
    restart();
    test_bad_length();
    restart();
    test_zero_len();
    restart();
    test_timeout();
    restart();
    test_timeout_edge();
    restart();
    test_gaps();
    restart();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
